// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with configurable data width, parity and stop bits, LSB first.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry transmit FIFO ahead of the shifter.
module uart_tx_cfg #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_fTx,
    input  logic [DATA_BITS-1:0] i_Data,
    output logic                 o_fReady,
    output logic                 o_fBusy,
    output logic                 o_fDone,
    output logic                 o_Tx
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(DIV - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("uart_tx_cfg: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shifter;
    logic                   par_bit;
    logic                   tx_q;
    logic                   done_q;

    logic                   bit_tick;
    logic                   frame_end;
    logic                   start;
    logic [DATA_BITS-1:0]   head;

    assign bit_tick  = (cnt == CNT_LAST);
    assign frame_end = (state == S_STOP) && bit_tick && (stop_idx == STOP_LAST);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [AW:0]          count;
    logic                 empty;
    logic                 full;
    logic                 can_start;
    logic                 pop;
    logic                 push;
    logic                 accept;

    assign empty     = (count == '0);
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign can_start = (state == S_IDLE) || frame_end;
    assign pop       = can_start && !empty;
    assign o_fReady  = !full || pop;
    assign accept    = i_fTx && o_fReady;
    assign start     = can_start && (!empty || accept);
    // An accepted word meeting an empty FIFO on a start edge goes straight to the shifter.
    assign push      = accept && !(can_start && empty);
    assign head      = empty ? i_Data : mem[rd_ptr];

    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    assign o_fReady = (state == S_IDLE);
    assign start    = i_fTx && o_fReady;
    assign head     = i_Data;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shifter  <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            // Registered pulse: raised one edge early so it covers the last stop-bit cycle.
            done_q <= (state == S_STOP) && (stop_idx == STOP_LAST) && (cnt == CNT_PRE);
            if (start) begin
                state    <= S_START;
                cnt      <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                shifter  <= head;
                par_bit  <= (PARITY == 1) ? ~^head : ^head;
                tx_q     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        tx_q <= 1'b1;
                        cnt  <= '0;
                    end
                    S_START: begin
                        if (bit_tick) begin
                            state   <= S_DATA;
                            cnt     <= '0;
                            tx_q    <= shifter[0];
                            shifter <= shifter >> 1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (bit_tick) begin
                            cnt <= '0;
                            if (bit_idx == BIT_LAST) begin
                                if (PARITY != 0) begin
                                    state <= S_PARITY;
                                    tx_q  <= par_bit;
                                end else begin
                                    state <= S_STOP;
                                    tx_q  <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                                tx_q    <= shifter[0];
                                shifter <= shifter >> 1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (bit_tick) begin
                            state <= S_STOP;
                            cnt   <= '0;
                            tx_q  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_STOP: begin
                        if (bit_tick) begin
                            cnt <= '0;
                            if (stop_idx == STOP_LAST) begin
                                state <= S_IDLE;
                                tx_q  <= 1'b1;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_fBusy = (state != S_IDLE);
    assign o_fDone = done_q;
    assign o_Tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: four parameterisations at DIV = 10 checked against a line model.
module tb_uart_tx_cfg;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BAUD   = 5_000_000;
    localparam int          DIV    = 10;
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_BUILD = 1'b1;
`else
    localparam bit FIFO_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ftx = '0;
    logic [3:0] tx, ready, busy, done;
    logic [7:0] din [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instance table: 0 = 8N1, 1 = 8E2, 2 = 7O1, 3 = 8O1
    function automatic int cfg_nb(input int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        case (i)
            1:       return 2;
            2, 3:    return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_stop(input int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic int frame_cycles(input int i);
        return (1 + cfg_nb(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i)) * DIV;
    endfunction

    // Line level of bit position p within a frame carrying word w
    function automatic logic model_bit(input int i, input logic [7:0] w, input int p);
        int nb;
        int ones;
        nb   = cfg_nb(i);
        ones = 0;
        for (int b = 0; b < nb; b++) ones += int'(w[b]);
        if (p == 0) return 1'b0;
        if (p <= nb) return w[p-1];
        if (cfg_par(i) != 0 && p == nb + 1)
            return (cfg_par(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    uart_tx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_8n1 (
        .i_Clk(clk), .i_Rst(rst), .i_fTx(ftx[0]), .i_Data(din[0]),
        .o_fReady(ready[0]), .o_fBusy(busy[0]), .o_fDone(done[0]), .o_Tx(tx[0]));

    uart_tx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_8e2 (
        .i_Clk(clk), .i_Rst(rst), .i_fTx(ftx[1]), .i_Data(din[1]),
        .o_fReady(ready[1]), .o_fBusy(busy[1]), .o_fDone(done[1]), .o_Tx(tx[1]));

    uart_tx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_7o1 (
        .i_Clk(clk), .i_Rst(rst), .i_fTx(ftx[2]), .i_Data(din[2][6:0]),
        .o_fReady(ready[2]), .o_fBusy(busy[2]), .o_fDone(done[2]), .o_Tx(tx[2]));

    uart_tx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_8o1 (
        .i_Clk(clk), .i_Rst(rst), .i_fTx(ftx[3]), .i_Data(din[3]),
        .o_fReady(ready[3]), .o_fBusy(busy[3]), .o_fDone(done[3]), .o_Tx(tx[3]));

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (tx !== 4'b1111) begin fails++; $display("FAIL reset_tx got %b want 1111", tx); end
        tests++;
        if (ready !== 4'b1111) begin fails++; $display("FAIL reset_ready got %b want 1111", ready); end
        tests++;
        if (busy !== 4'b0000) begin fails++; $display("FAIL reset_busy got %b want 0000", busy); end
        tests++;
        if (done !== 4'b0000) begin fails++; $display("FAIL reset_done got %b want 0000", done); end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (tx !== 4'b1111 || busy !== 4'b0000) begin
            fails++;
            $display("FAIL post_reset_idle tx=%b busy=%b want 1111/0000", tx, busy);
        end
    endtask

    // Sends one word from idle and checks every cycle from k+1 to k+F+1; optionally pokes
    // a second write mid-frame and then checks that the line stays idle for a frame time.
    task automatic send_frame(input int i, input logic [7:0] w, input bit poke);
        int   f;
        int   tail;
        logic exp_tx, exp_busy, exp_done, exp_ready;
        f    = frame_cycles(i);
        tail = poke ? f : 1;
        @(negedge clk);
        tests++;
        if (ready[i] !== 1'b1) begin
            fails++; $display("FAIL ready_before_send inst%0d got %b want 1", i, ready[i]);
        end
        ftx[i] = 1'b1;
        din[i] = w;
        for (int c = 1; c <= f + tail; c++) begin
            @(negedge clk);
            ftx[i] = (poke && c == f / 2) ? 1'b1 : 1'b0;
            din[i] = 8'($urandom);
            exp_tx    = (c <= f) ? model_bit(i, w, (c - 1) / DIV) : 1'b1;
            exp_busy  = (c <= f);
            exp_done  = (c == f);
            exp_ready = FIFO_BUILD ? 1'b1 : !exp_busy;
            tests++;
            if (tx[i] !== exp_tx) begin
                fails++; $display("FAIL line inst%0d w=%h cycle %0d got %b want %b", i, w, c, tx[i], exp_tx);
            end
            tests++;
            if (done[i] !== exp_done) begin
                fails++; $display("FAIL done inst%0d cycle %0d got %b want %b", i, c, done[i], exp_done);
            end
            tests++;
            if (busy[i] !== exp_busy) begin
                fails++; $display("FAIL busy inst%0d cycle %0d got %b want %b", i, c, busy[i], exp_busy);
            end
            tests++;
            if (ready[i] !== exp_ready) begin
                fails++; $display("FAIL ready inst%0d cycle %0d got %b want %b", i, c, ready[i], exp_ready);
            end
        end
        ftx[i] = 1'b0;
    endtask

    task automatic test_directed();
        send_frame(0, 8'hA5, 1'b0);
        send_frame(1, 8'hA5, 1'b0);
        send_frame(3, 8'hA5, 1'b0);
        send_frame(2, 8'h00, 1'b0);
        send_frame(2, 8'h7F, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) begin
                send_frame(i, 8'($urandom), 1'b0);
            end
        end
    endtask

    task automatic test_ignore_busy();
        send_frame(0, 8'($urandom), 1'b1);
        send_frame(1, 8'($urandom), 1'b1);
    endtask

    // Six writes on consecutive edges: five accepted, the sixth refused while full.
    task automatic test_back_to_back();
        logic [7:0] w [6];
        int   f;
        logic exp_tx, exp_busy, exp_done;
        f = frame_cycles(0);
        for (int j = 0; j < 6; j++) w[j] = 8'($urandom);
        for (int n = 0; n <= 5 * f + 3; n++) begin
            @(negedge clk);
            if (n >= 1) begin
                exp_tx   = (n <= 5 * f) ? model_bit(0, w[(n - 1) / f], ((n - 1) % f) / DIV) : 1'b1;
                exp_busy = (n <= 5 * f);
                exp_done = (n <= 5 * f) && (n % f == 0);
                tests++;
                if (tx[0] !== exp_tx) begin
                    fails++; $display("FAIL b2b_line cycle %0d got %b want %b", n, tx[0], exp_tx);
                end
                tests++;
                if (busy[0] !== exp_busy) begin
                    fails++; $display("FAIL b2b_busy cycle %0d got %b want %b", n, busy[0], exp_busy);
                end
                tests++;
                if (done[0] !== exp_done) begin
                    fails++; $display("FAIL b2b_done cycle %0d got %b want %b", n, done[0], exp_done);
                end
            end
            if (n <= 5 || n > 5 * f) begin
                tests++;
                if (ready[0] !== (n < 5 || n > 5 * f)) begin
                    fails++; $display("FAIL b2b_ready cycle %0d got %b want %b", n, ready[0], (n < 5 || n > 5 * f));
                end
            end
            if (n <= 5) begin
                ftx[0] = 1'b1;
                din[0] = w[n];
            end else begin
                ftx[0] = 1'b0;
                din[0] = 8'($urandom);
            end
        end
    endtask

    // Reset in the middle of a data bit with words still queued (FIFO build).
    task automatic test_reset_midframe();
        int nq;
        int f;
        f  = frame_cycles(0);
        nq = FIFO_BUILD ? 3 : 1;
        for (int j = 0; j < nq; j++) begin
            @(negedge clk);
            ftx[0] = 1'b1;
            din[0] = 8'($urandom);
        end
        @(negedge clk);
        ftx[0] = 1'b0;
        repeat (25 - nq) @(negedge clk);
        tests++;
        if (busy[0] !== 1'b1) begin
            fails++; $display("FAIL midframe_busy_before_reset got %b want 1", busy[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 3 * f; c++) begin
            if (c > 0) @(negedge clk);
            tests++;
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || ready[0] !== 1'b1) begin
                fails++;
                $display("FAIL after_reset cycle %0d tx=%b busy=%b done=%b ready=%b want 1/0/0/1",
                         c, tx[0], busy[0], done[0], ready[0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = '0;
        test_reset();
        test_directed();
        test_random();
`ifdef UART_TX_FIFO_EN
        test_back_to_back();
`else
        test_ignore_busy();
`endif
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, the successor to the team's fixed 8N1 transmitter. It serialises words of configurable width with optional parity and one or two stop bits, LSB first, at a bit period derived from clock frequency and baud rate. An optional transmit FIFO accepts back-to-back words and sends them with no idle gap between frames. It sits between any byte-producing engine and the board TX pin.

## Interface
- CLK_HZ, 50_000_000: system clock frequency in Hz
- BAUD, 115200: line rate; DIV = CLK_HZ / BAUD, integer-truncated, must be ≥ 2
- DATA_BITS, 8: data bits per frame, legal range 5..9
- PARITY, 0: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1: 1 or 2
- FIFO_DEPTH, 4: FIFO entries, power of 2, ≥ 2; only used when UART_TX_FIFO_EN is defined

- i_Clk  in  1  single clock; all logic on the rising edge
- i_Rst  in  1  reset, synchronous, active-high
- i_fTx  in  1  write strobe; a word is accepted on an edge where i_fTx && o_fReady
- i_Data  in  DATA_BITS  word to send, sampled on the accepting edge
- o_fReady  out  1  a write will be accepted this cycle
- o_fBusy  out  1  a frame is on the line (any state other than IDLE)
- o_fDone  out  1  one-cycle pulse in the final cycle of the last stop bit
- o_Tx  out  1  serial line, idle high

## Operation
- Reset values: o_Tx = 1, o_fReady = 1, o_fBusy = 0, o_fDone = 0. The FSM is in IDLE, the FIFO is empty, and all counters are 0.
- FSM states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE, or STOP → START when another word is pending.
- Frame, in line order: start bit 0; data bits d[0]..d[DATA_BITS-1]; parity bit; STOP_BITS high bits.
  - Odd parity bit = ~^data.
  - Even parity bit = ^data.
- Every bit, including each stop bit, is held for exactly DIV cycles. The bit counter runs 0..DIV-1 and the bit advances when the count is DIV-1.
- Frame length is F = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × DIV cycles.
- The shift register is loaded from the head word at frame start. Later changes to i_Data or new writes never disturb a frame in flight.
- Pending word at the end of STOP: the FSM goes directly to START on the next edge. The start bit immediately follows the last stop bit, with no extra idle cycle.
- Write while not ready: the word is dropped and no state changes.
- Write and frame-start pop on the same edge: both take effect. Occupancy stays unchanged, and the write is legal while the FIFO is full only if that same edge pops.
- Reset mid-frame: on the next edge o_Tx = 1, the FSM returns to IDLE and the FIFO is flushed. No o_fDone pulse is produced for the aborted frame.
- Unused upper bits of the data shifter are not transmitted. Width is exactly DATA_BITS.

## Timing
- A word accepted on edge k from IDLE with an empty queue drives o_Tx low starting cycle k+1.
- o_fBusy rises in cycle k+1.
- o_fDone is high during cycle k+F. The line returns to IDLE (o_Tx = 1, o_fBusy = 0) in cycle k+F+1 unless another word is pending.
- Back-to-back frames: the next start bit begins in cycle k+F+1, so o_fBusy stays high throughout.
- o_fReady is registered-state combinational.
  - Without FIFO: o_fReady = IDLE.
  - With FIFO: o_fReady = !full || pop_this_cycle.
- There is no combinational path from i_Data to o_Tx. o_Tx is a register output.

## Configuration
- UART_TX_FIFO_EN defined:
  - A FIFO_DEPTH-entry FIFO with DATA_BITS-wide entries sits ahead of the shifter.
  - The head entry is popped on the edge the FSM enters START.
  - o_fReady stays high while the FIFO has space, including during transmission.
- UART_TX_FIFO_EN undefined:
  - A single holding register is used and FIFO_DEPTH is ignored.
  - o_fReady = 1 only in IDLE, so the accepting edge is also the frame-start edge.
  - There is no back-to-back sending; one idle cycle always separates frames.

## Test plan
- CLK_HZ = 50e6, BAUD = 5e6 (DIV = 10), 8N1, send 8'hA5.
  - Required line, LSB first, 10 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - o_fDone is high exactly at cycle k+100 and o_fBusy is low at k+101.
- 8E2 with 8'hA5: the parity bit is 0 and the frame is 120 cycles. Odd parity with the same word gives parity 1.
- 7O1 with 7'h00: the parity bit is 1, the frame is 100 cycles, and exactly 7 data bits are sent.
- FIFO enabled, depth 4: write 6 words on consecutive cycles.
  - The first 5 are accepted (one is popped immediately) and the 6th is dropped while o_fReady = 0.
  - The 5 frames are sent contiguously, with the start bit directly after each stop bit.
- Assert i_Rst for one cycle mid-data-bit with 2 words queued.
  - o_Tx = 1 and o_fBusy = 0 on the next cycle, with no o_fDone pulse.
  - No further frames are sent.
- FIFO disabled: pulse i_fTx during a frame. The word is ignored, and the line carries only the original frame.
